// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the multicycle RV64 control path:
// FSM state encoding, opcode/funct3 values and datapath select encodings.
package riscv_ctrl_pkg;

    typedef enum logic [4:0] {
        ST_RESET   = 5'd0,
        ST_FETCH   = 5'd1,
        ST_DECODE  = 5'd2,
        ST_EXEC_R  = 5'd3,
        ST_EXEC_I  = 5'd4,
        ST_ADDR    = 5'd5,
        ST_LD_MEM  = 5'd6,
        ST_LD_WB   = 5'd7,
        ST_SD_MEM  = 5'd8,
        ST_BRANCH  = 5'd9,
        ST_LUI     = 5'd10,
        ST_JAL     = 5'd11,
        ST_WB_ALU  = 5'd12,
        ST_ILLEGAL = 5'd13,
        ST_HALT    = 5'd14
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [2:0] F3_OR    = 3'b110;
    localparam logic [2:0] F3_AND   = 3'b111;
    localparam logic [2:0] F3_DWORD = 3'b011;
    localparam logic [2:0] F3_BEQ   = 3'b000;
    localparam logic [2:0] F3_BNE   = 3'b001;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'd0,
        ALU_SUB    = 3'd1,
        ALU_AND    = 3'd2,
        ALU_OR     = 3'd3,
        ALU_PASS_B = 3'd4
    } alu_op_t;

    typedef enum logic [1:0] {
        SRC_A_PC     = 2'd0,
        SRC_A_REG    = 2'd1,
        SRC_A_PC_OLD = 2'd2
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRC_B_REG  = 2'd0,
        SRC_B_FOUR = 2'd1,
        SRC_B_IMM  = 2'd2
    } alu_src_b_t;

    typedef enum logic [1:0] {
        WB_SEL_ALU_OUT = 2'd0,
        WB_SEL_MDR     = 2'd1,
        WB_SEL_PC      = 2'd2
    } mem_to_reg_t;

    typedef enum logic [1:0] {
        PC_SEL_ALU     = 2'd0,
        PC_SEL_ALU_OUT = 2'd1,
        PC_SEL_EXC     = 2'd2
    } pc_src_t;

    // Dispatch target out of DECODE; anything unsupported lands in ILLEGAL.
    function automatic state_t decode_target(input logic [6:0] op, input logic [2:0] f3);
        state_t tgt;
        tgt = ST_ILLEGAL;
        case (op)
            OP_RTYPE: tgt = ST_EXEC_R;
            OP_ITYPE: tgt = ST_EXEC_I;
            OP_LOAD, OP_STORE: begin
                if (f3 == F3_DWORD) tgt = ST_ADDR;
                else                tgt = ST_ILLEGAL;
            end
            OP_BRANCH: begin
                if ((f3 == F3_BEQ) || (f3 == F3_BNE)) tgt = ST_BRANCH;
                else                                  tgt = ST_ILLEGAL;
            end
            OP_LUI:    tgt = ST_LUI;
            OP_JAL:    tgt = ST_JAL;
            OP_SYSTEM: tgt = ST_HALT;
            default:   tgt = ST_ILLEGAL;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Cycle counter that stretches memory states to MEM_LAT cycles.
// done is high on the final cycle of an access; the count saturates there.
module mem_wait_counter #(
    parameter int unsigned MEM_LAT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic done
);

    logic [3:0] cnt_r;
    logic       done_s;

    assign done_s = (cnt_r == 4'(MEM_LAT - 1));
    assign done   = done_s;

    // Count up while in a state, restart on every state change or reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r <= 4'd0;
        end else if (clear) begin
            cnt_r <= 4'd0;
        end else if (!done_s) begin
            cnt_r <= cnt_r + 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV64 core. One instruction at a time:
// fetch, decode, execute/memory, write-back. Outputs are a Moore decode of the
// state and the memory wait counter, except branch pc_write which uses zero.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       addr_src,
    output logic       load_ab,
    output logic       load_alu_out,
    output logic       load_mdr,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] mem_to_reg,
    output logic [1:0] pc_src,
    output logic       exception,
    output logic [4:0] state_out
);

    state_t      state_r;
    state_t      state_nxt_s;
    logic        wait_done_s;
    logic        state_chg_s;

    logic        pc_write_s;
    logic        ir_write_s;
    logic        mem_rd_s;
    logic        mem_wr_s;
    logic        addr_src_s;
    logic        load_ab_s;
    logic        load_alu_out_s;
    logic        load_mdr_s;
    logic        reg_write_s;
    alu_src_a_t  alu_src_a_s;
    alu_src_b_t  alu_src_b_s;
    alu_op_t     alu_op_s;
    mem_to_reg_t mem_to_reg_s;
    pc_src_t     pc_src_s;
    logic        exception_s;

    // Only funct7[5] distinguishes the supported R-type operations.
    logic        unused_funct7_s;
    assign unused_funct7_s = ^{funct7[6], funct7[4:0]};

    assign state_chg_s = (state_nxt_s != state_r);

    mem_wait_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_wait (
        .clk   (clk),
        .reset (reset),
        .clear (state_chg_s),
        .done  (wait_done_s)
    );

    // State register; reset forces RESET so any memory strobe drops next cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_RESET;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and control decode for the current state.
    always_comb begin
        state_nxt_s    = state_r;
        pc_write_s     = 1'b0;
        ir_write_s     = 1'b0;
        mem_rd_s       = 1'b0;
        mem_wr_s       = 1'b0;
        addr_src_s     = 1'b0;
        load_ab_s      = 1'b0;
        load_alu_out_s = 1'b0;
        load_mdr_s     = 1'b0;
        reg_write_s    = 1'b0;
        alu_src_a_s    = SRC_A_PC;
        alu_src_b_s    = SRC_B_REG;
        alu_op_s       = ALU_ADD;
        mem_to_reg_s   = WB_SEL_ALU_OUT;
        pc_src_s       = PC_SEL_ALU;
        exception_s    = 1'b0;

        case (state_r)
            ST_RESET: begin
                state_nxt_s = ST_FETCH;
            end

            ST_FETCH: begin
                mem_rd_s = 1'b1;
                if (wait_done_s) begin
                    // Instruction arrives: latch IR and advance PC to PC+4.
                    ir_write_s  = 1'b1;
                    pc_write_s  = 1'b1;
                    alu_src_b_s = SRC_B_FOUR;
                    state_nxt_s = ST_DECODE;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end

            ST_DECODE: begin
                // Precompute the branch/jump target pc_old+imm into ALUOut.
                load_ab_s      = 1'b1;
                load_alu_out_s = 1'b1;
                alu_src_a_s    = SRC_A_PC_OLD;
                alu_src_b_s    = SRC_B_IMM;
                state_nxt_s    = decode_target(opcode, funct3);
            end

            ST_EXEC_R: begin
                alu_src_a_s = SRC_A_REG;
                alu_src_b_s = SRC_B_REG;
                case (funct3)
                    F3_ADD: begin
                        alu_op_s       = funct7[5] ? ALU_SUB : ALU_ADD;
                        load_alu_out_s = 1'b1;
                        state_nxt_s    = ST_WB_ALU;
                    end
                    F3_AND: begin
                        alu_op_s       = ALU_AND;
                        load_alu_out_s = 1'b1;
                        state_nxt_s    = ST_WB_ALU;
                    end
                    F3_OR: begin
                        alu_op_s       = ALU_OR;
                        load_alu_out_s = 1'b1;
                        state_nxt_s    = ST_WB_ALU;
                    end
                    default: begin
                        state_nxt_s = ST_ILLEGAL;
                    end
                endcase
            end

            ST_EXEC_I: begin
                alu_src_a_s = SRC_A_REG;
                alu_src_b_s = SRC_B_IMM;
                if (funct3 == F3_ADD) begin
                    load_alu_out_s = 1'b1;
                    state_nxt_s    = ST_WB_ALU;
                end else begin
                    state_nxt_s = ST_ILLEGAL;
                end
            end

            ST_LUI: begin
                alu_src_b_s    = SRC_B_IMM;
                alu_op_s       = ALU_PASS_B;
                load_alu_out_s = 1'b1;
                state_nxt_s    = ST_WB_ALU;
            end

            ST_WB_ALU: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = WB_SEL_ALU_OUT;
                state_nxt_s  = ST_FETCH;
            end

            ST_ADDR: begin
                alu_src_a_s    = SRC_A_REG;
                alu_src_b_s    = SRC_B_IMM;
                load_alu_out_s = 1'b1;
                // opcode[5] separates store (0100011) from load (0000011).
                if (opcode[5] == 1'b0) state_nxt_s = ST_LD_MEM;
                else                   state_nxt_s = ST_SD_MEM;
            end

            ST_LD_MEM: begin
                mem_rd_s   = 1'b1;
                addr_src_s = 1'b1;
                if (wait_done_s) begin
                    load_mdr_s  = 1'b1;
                    state_nxt_s = ST_LD_WB;
                end else begin
                    state_nxt_s = ST_LD_MEM;
                end
            end

            ST_LD_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = WB_SEL_MDR;
                state_nxt_s  = ST_FETCH;
            end

            ST_SD_MEM: begin
                mem_wr_s   = 1'b1;
                addr_src_s = 1'b1;
                if (wait_done_s) state_nxt_s = ST_FETCH;
                else             state_nxt_s = ST_SD_MEM;
            end

            ST_BRANCH: begin
                // funct3[0] inverts the sense: beq takes on zero, bne on !zero.
                alu_src_a_s = SRC_A_REG;
                alu_src_b_s = SRC_B_REG;
                alu_op_s    = ALU_SUB;
                pc_write_s  = zero ^ funct3[0];
                pc_src_s    = PC_SEL_ALU_OUT;
                state_nxt_s = ST_FETCH;
            end

            ST_JAL: begin
                // PC already holds the link value PC+4; target sits in ALUOut.
                reg_write_s  = 1'b1;
                mem_to_reg_s = WB_SEL_PC;
                pc_write_s   = 1'b1;
                pc_src_s     = PC_SEL_ALU_OUT;
                state_nxt_s  = ST_FETCH;
            end

            ST_ILLEGAL: begin
                exception_s = 1'b1;
                pc_write_s  = 1'b1;
                pc_src_s    = PC_SEL_EXC;
                state_nxt_s = ST_FETCH;
            end

            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end

            default: begin
                state_nxt_s = ST_RESET;
            end
        endcase
    end

    assign pc_write     = pc_write_s;
    assign ir_write     = ir_write_s;
    assign mem_rd       = mem_rd_s;
    assign mem_wr       = mem_wr_s;
    assign addr_src     = addr_src_s;
    assign load_ab      = load_ab_s;
    assign load_alu_out = load_alu_out_s;
    assign load_mdr     = load_mdr_s;
    assign reg_write    = reg_write_s;
    assign alu_src_a    = alu_src_a_s;
    assign alu_src_b    = alu_src_b_s;
    assign alu_op       = alu_op_s;
    assign mem_to_reg   = mem_to_reg_s;
    assign pc_src       = pc_src_s;
    assign exception    = exception_s;
    assign state_out    = state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instruction table with expected state
// paths, a per-cycle trace model built from the instruction semantics, reset
// corner cases and randomized instruction streams.
module tb_multicycle_control;

    localparam int L        = 3;
    localparam int HALT_LEN = 20;

    localparam logic [9:0] S_PCW  = 10'b1000000000;
    localparam logic [9:0] S_IRW  = 10'b0100000000;
    localparam logic [9:0] S_MRD  = 10'b0010000000;
    localparam logic [9:0] S_MWR  = 10'b0001000000;
    localparam logic [9:0] S_AS   = 10'b0000100000;
    localparam logic [9:0] S_LAB  = 10'b0000010000;
    localparam logic [9:0] S_LAO  = 10'b0000001000;
    localparam logic [9:0] S_LMDR = 10'b0000000100;
    localparam logic [9:0] S_RW   = 10'b0000000010;
    localparam logic [9:0] S_EXC  = 10'b0000000001;

    localparam logic [6:0] R_OP  = 7'b0110011;
    localparam logic [6:0] I_OP  = 7'b0010011;
    localparam logic [6:0] LD_OP = 7'b0000011;
    localparam logic [6:0] SD_OP = 7'b0100011;
    localparam logic [6:0] BR_OP = 7'b1100011;
    localparam logic [6:0] LU_OP = 7'b0110111;
    localparam logic [6:0] JL_OP = 7'b1101111;
    localparam logic [6:0] SY_OP = 7'b1110011;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;
    logic       pc_write, ir_write, mem_rd, mem_wr, addr_src, load_ab;
    logic       load_alu_out, load_mdr, reg_write, exception;
    logic [1:0] alu_src_a, alu_src_b, mem_to_reg, pc_src;
    logic [2:0] alu_op;
    logic [4:0] state_out;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_LAT(L)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .zero(zero), .pc_write(pc_write), .ir_write(ir_write),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .addr_src(addr_src), .load_ab(load_ab),
        .load_alu_out(load_alu_out), .load_mdr(load_mdr), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .mem_to_reg(mem_to_reg), .pc_src(pc_src), .exception(exception),
        .state_out(state_out)
    );

    typedef struct packed {
        logic [4:0] st;
        logic [9:0] strb;
        logic [1:0] asa;
        logic [1:0] asb;
        logic [2:0] aop;
        logic [1:0] m2r;
        logic [1:0] psrc;
    } exp_t;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        z;
        int          plen;
        logic [29:0] path;
    } vec_t;

    exp_t q[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic exp_t observe();
        return exp_t'({state_out, pc_write, ir_write, mem_rd, mem_wr, addr_src, load_ab,
                       load_alu_out, load_mdr, reg_write, exception, alu_src_a, alu_src_b,
                       alu_op, mem_to_reg, pc_src});
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic push(input int st, input logic [9:0] strb, input int asa, input int asb,
                        input int aop, input int m2r, input int psrc);
        q.push_back(exp_t'({5'(st), strb, 2'(asa), 2'(asb), 3'(aop), 2'(m2r), 2'(psrc)}));
    endtask

    task automatic push_illegal();
        push(13, S_EXC | S_PCW, 0, 0, 0, 0, 2);
    endtask

    task automatic push_wb();
        push(12, S_RW, 0, 0, 0, 0, 0);
    endtask

    // Expected cycle-by-cycle control trace of one instruction, from its semantics.
    task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic z);
        for (int i = 0; i < L; i++) begin
            if (i == L - 1) push(1, S_MRD | S_PCW | S_IRW, 0, 1, 0, 0, 0);
            else            push(1, S_MRD, 0, 0, 0, 0, 0);
        end
        push(2, S_LAB | S_LAO, 2, 2, 0, 0, 0);
        case (op)
            R_OP: begin
                if (f3 == 3'd0)      begin push(3, S_LAO, 1, 0, f7[5] ? 1 : 0, 0, 0); push_wb(); end
                else if (f3 == 3'd7) begin push(3, S_LAO, 1, 0, 2, 0, 0); push_wb(); end
                else if (f3 == 3'd6) begin push(3, S_LAO, 1, 0, 3, 0, 0); push_wb(); end
                else                 begin push(3, 10'd0, 1, 0, 0, 0, 0); push_illegal(); end
            end
            I_OP: begin
                if (f3 == 3'd0) begin push(4, S_LAO, 1, 2, 0, 0, 0); push_wb(); end
                else            begin push(4, 10'd0, 1, 2, 0, 0, 0); push_illegal(); end
            end
            LD_OP, SD_OP: begin
                if (f3 == 3'd3) begin
                    push(5, S_LAO, 1, 2, 0, 0, 0);
                    for (int i = 0; i < L; i++) begin
                        if (op == LD_OP) push(6, S_MRD | S_AS | ((i == L - 1) ? S_LMDR : 10'd0), 0, 0, 0, 0, 0);
                        else             push(8, S_MWR | S_AS, 0, 0, 0, 0, 0);
                    end
                    if (op == LD_OP) push(7, S_RW, 0, 0, 0, 1, 0);
                end else begin
                    push_illegal();
                end
            end
            BR_OP: begin
                if (f3 == 3'd0)      push(9, z ? S_PCW : 10'd0, 1, 0, 1, 0, 1);
                else if (f3 == 3'd1) push(9, z ? 10'd0 : S_PCW, 1, 0, 1, 0, 1);
                else                 push_illegal();
            end
            LU_OP: begin push(10, S_LAO, 0, 2, 4, 0, 0); push_wb(); end
            JL_OP: push(11, S_RW | S_PCW, 0, 0, 0, 2, 1);
            SY_OP: for (int i = 0; i < HALT_LEN; i++) push(14, 10'd0, 0, 0, 0, 0, 0);
            default: push_illegal();
        endcase
    endtask

    // Drive one instruction and compare every cycle (up to limit, 0 = all).
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic z, input int limit, output logic [29:0] path,
                             output int npath);
        exp_t e, o;
        int   n;
        opcode = op; funct3 = f3; funct7 = f7; zero = z;
        q.delete();
        model(op, f3, f7, z);
        path = 30'd0; npath = 0; n = 0;
        while ((q.size() > 0) && ((limit == 0) || (n < limit))) begin
            e = q.pop_front();
            @(negedge clk);
            o = observe();
            check("trace", 32'(o), 32'(e));
            if ((n >= L) && (npath < 6)) begin
                path[5*npath +: 5] = o.st;
                npath++;
            end
            n++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("reset_outputs", 32'(observe()), 32'd0);
        end
        reset = 1'b1;
    endtask

    task automatic add_vec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic z, input int plen, input int s0, input int s1,
                           input int s2, input int s3, input int s4, input int s5);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.plen = plen;
        v.path = {5'(s5), 5'(s4), 5'(s3), 5'(s2), 5'(s1), 5'(s0)};
        vecs.push_back(v);
    endtask

    initial begin
        logic [29:0] path;
        int          np;
        logic [6:0]  rop;
        logic [2:0]  rf3;

        reset = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0; zero = 1'b0;

        add_vec(R_OP,  3'b000, 7'h00, 1'b0, 3, 2, 3, 12, 0, 0, 0);  // add x3,x1,x2
        add_vec(R_OP,  3'b000, 7'h20, 1'b0, 3, 2, 3, 12, 0, 0, 0);  // sub
        add_vec(R_OP,  3'b111, 7'h00, 1'b0, 3, 2, 3, 12, 0, 0, 0);  // and
        add_vec(R_OP,  3'b110, 7'h00, 1'b0, 3, 2, 3, 12, 0, 0, 0);  // or
        add_vec(R_OP,  3'b001, 7'h00, 1'b0, 3, 2, 3, 13, 0, 0, 0);  // unsupported sll
        add_vec(I_OP,  3'b000, 7'h00, 1'b0, 3, 2, 4, 12, 0, 0, 0);  // addi
        add_vec(I_OP,  3'b100, 7'h00, 1'b0, 3, 2, 4, 13, 0, 0, 0);  // xori -> illegal
        add_vec(LD_OP, 3'b011, 7'h00, 1'b0, 6, 2, 5, 6, 6, 6, 7);   // ld
        add_vec(SD_OP, 3'b011, 7'h00, 1'b0, 5, 2, 5, 8, 8, 8, 0);   // sd
        add_vec(LD_OP, 3'b010, 7'h00, 1'b0, 2, 2, 13, 0, 0, 0, 0);  // lw -> illegal
        add_vec(BR_OP, 3'b000, 7'h00, 1'b1, 2, 2, 9, 0, 0, 0, 0);   // beq taken
        add_vec(BR_OP, 3'b001, 7'h00, 1'b1, 2, 2, 9, 0, 0, 0, 0);   // bne not taken
        add_vec(BR_OP, 3'b001, 7'h00, 1'b0, 2, 2, 9, 0, 0, 0, 0);   // bne taken
        add_vec(BR_OP, 3'b100, 7'h00, 1'b0, 2, 2, 13, 0, 0, 0, 0);  // blt -> illegal
        add_vec(LU_OP, 3'b000, 7'h00, 1'b0, 3, 2, 10, 12, 0, 0, 0); // lui
        add_vec(JL_OP, 3'b000, 7'h00, 1'b0, 2, 2, 11, 0, 0, 0, 0);  // jal
        add_vec(7'h7F, 3'b000, 7'h00, 1'b0, 2, 2, 13, 0, 0, 0, 0);  // bad opcode

        do_reset();

        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, 0, path, np);
            check("path_len", 32'(np), 32'(vecs[i].plen));
            check("path", 32'(path), 32'(vecs[i].path));
        end

        // ebreak: HALT absorbs for HALT_LEN cycles, only reset leaves it.
        run_instr(SY_OP, 3'b000, 7'h00, 1'b0, 0, path, np);
        do_reset();

        // Reset during LD_MEM cycle 2: strobes must drop and no MDR load follows.
        run_instr(LD_OP, 3'b011, 7'h00, 1'b0, L + 2 + 2, path, np);
        check("midreset_mem_rd_before", 32'(mem_rd), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_state", 32'(observe()), 32'd0);
        @(negedge clk);
        check("midreset_hold", 32'(observe()), 32'd0);
        reset = 1'b1;
        run_instr(R_OP, 3'b000, 7'h00, 1'b0, 0, path, np);
        check("after_reset_path", 32'(path), 32'({5'd12, 5'd3, 5'd2}));

        // Randomized instruction stream against the trace model.
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 8))
                0: rop = R_OP;  1: rop = I_OP;  2: rop = LD_OP;
                3: rop = SD_OP; 4: rop = BR_OP; 5: rop = LU_OP;
                6: rop = JL_OP; 7: rop = BR_OP;
                default: rop = 7'($urandom_range(0, 127));
            endcase
            if (rop == SY_OP) rop = 7'h7F;
            rf3 = 3'($urandom_range(0, 7));
            if (((rop == LD_OP) || (rop == SD_OP)) && ($urandom_range(0, 3) != 0)) rf3 = 3'd3;
            run_instr(rop, rf3, 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 0, path, np);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
